// File: rtl/arb_defs_pkg.sv
// Shared definitions for the four-way round-robin arbiter: state encoding,
// register widths and the rotating-priority winner search.
package arb_defs;

  localparam int STATE_W = 2;
  localparam int COUNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RELEASE = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  // Returns {found, index}. Requester ptr+1 has the highest priority and
  // ptr itself the lowest, so the last winner is served again only when
  // nobody else is asking.
  function automatic logic [2:0] pick_winner(input logic [1:0] ptr,
                                             input logic [0:3] req);
    logic [2:0] pick;
    logic [1:0] cand;
    pick = 3'b000;
    // Walk from lowest to highest priority so the highest one written last wins.
    for (int k = 4; k >= 1; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) pick = {1'b1, cand};
    end
    return pick;
  endfunction

endpackage

// File: rtl/decoder_2x4_gates.sv
// Gate-level 2-to-4 decoder with active-low enable and active-low outputs.
// Output y_n[{a,b}] goes low when enabled; all outputs stay high otherwise.
module decoder_2x4_gates (
  input  logic       a,
  input  logic       b,
  input  logic       en_n,
  output logic [0:3] y_n
);

  logic a_n;
  logic b_n;
  logic en;

  assign a_n = ~a;
  assign b_n = ~b;
  assign en  = ~en_n;

  assign y_n[0] = ~(a_n & b_n & en);
  assign y_n[1] = ~(a_n & b   & en);
  assign y_n[2] = ~(a   & b_n & en);
  assign y_n[3] = ~(a   & b   & en);

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with an optional hold limit.
// A grant lasts until done, until the holder drops its request, or until
// HOLD_MAX cycles have elapsed; each grant is followed by one RELEASE cycle
// and one IDLE cycle before the next winner is chosen.
module rr_arbiter_4
  import arb_defs::*;
#(
  parameter int HOLD_MAX = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [0:3] req,
  input  logic       done,
  output logic [0:3] grant_n,
  output logic [1:0] grant_idx,
  output logic       busy,
  output logic       timeout
);

  localparam logic [COUNT_W-1:0] HOLD_LIM = COUNT_W'(HOLD_MAX);

  state_t             state;
  logic [1:0]         ptr;
  logic [COUNT_W-1:0] count;

  logic [2:0]         win;
  logic               req_held;
  logic               hold_hit;
  logic               release_now;

  // Winner search and grant-exit conditions from the current registered state.
  always_comb begin
    win         = pick_winner(ptr, req);
    req_held    = req[grant_idx];
    hold_hit    = (HOLD_MAX != 0) && (count == HOLD_LIM);
    release_now = done || !req_held || hold_hit;
  end

  // Arbiter state machine: grant selection, hold counting and release pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 2'd3;
      grant_idx <= 2'd0;
      count     <= '0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (enable && win[2]) begin
            grant_idx <= win[1:0];
            ptr       <= win[1:0];
            count     <= COUNT_W'(1);
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            state   <= RELEASE;
            // Only a release caused purely by the hold limit is reported.
            timeout <= !done && req_held;
          end else begin
            count <= count + COUNT_W'(1);
          end
        end
        RELEASE: begin
          timeout <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          timeout <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state == GRANT);

  decoder_2x4_gates u_dec (
    .a    (grant_idx[1]),
    .b    (grant_idx[0]),
    .en_n (state != GRANT),
    .y_n  (grant_n)
  );

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: two instances (hold limits 3 and 2) share one
// stimulus stream; a behavioural model per instance is compared every cycle,
// and directed literal expectations pin the model at key points.
module tb_rr_arbiter_4;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [0:3] req;
  logic       done;

  logic [0:3] grant_n_a, grant_n_b;
  logic [1:0] grant_idx_a, grant_idx_b;
  logic       busy_a, busy_b;
  logic       timeout_a, timeout_b;

  int checks = 0;
  int errors = 0;

  rr_arbiter_4 #(.HOLD_MAX(3)) u_dut_a (
    .clock(clk), .reset(reset), .enable(enable), .req(req), .done(done),
    .grant_n(grant_n_a), .grant_idx(grant_idx_a), .busy(busy_a), .timeout(timeout_a)
  );

  rr_arbiter_4 #(.HOLD_MAX(2)) u_dut_b (
    .clock(clk), .reset(reset), .enable(enable), .req(req), .done(done),
    .grant_n(grant_n_b), .grant_idx(grant_idx_b), .busy(busy_b), .timeout(timeout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: who owns the resource, who won last, how long held.
  typedef struct {
    int owner;   // -1 when nobody holds the grant
    int last;    // last winner, drives rotation
    int shown;   // value visible on grant_idx
    int held;    // grant cycles so far
    bit rel;     // in the dead cycle right after a grant
    bit to;      // forced-release flag visible this cycle
  } mdl_t;

  mdl_t ma, mb;
  bit   primed = 1'b0;

  function automatic mdl_t mstep(mdl_t m, int hold, bit rst, bit en,
                                 logic [0:3] rq, bit dn);
    mdl_t n;
    bit   found;
    int   c;
    n    = m;
    n.to = 1'b0;
    if (rst) begin
      n.owner = -1; n.last = 3; n.shown = 0; n.held = 0; n.rel = 1'b0;
    end else if (m.owner >= 0) begin
      if (dn || !rq[m.owner] || (hold != 0 && m.held == hold)) begin
        n.to    = !dn && rq[m.owner];
        n.owner = -1;
        n.rel   = 1'b1;
      end else begin
        n.held = m.held + 1;
      end
    end else if (m.rel) begin
      n.rel = 1'b0;
    end else if (en) begin
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        c = (m.last + k) % 4;
        if (!found && rq[c]) begin
          found = 1'b1; n.owner = c; n.last = c; n.shown = c; n.held = 1;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [0:3] model_gn(mdl_t m);
    logic [0:3] g;
    g = 4'b1111;
    if (m.owner >= 0) g[m.owner] = 1'b0;
    return g;
  endfunction

  // Requester-indexed mask (bit i = requester i) onto the req port.
  function automatic logic [0:3] req_of(input logic [3:0] m);
    logic [0:3] r;
    for (int i = 0; i < 4; i++) r[i] = m[i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model advance on every rising edge with the inputs the DUT samples.
  always @(posedge clk) begin
    if (reset) primed = 1'b1;
    ma = mstep(ma, 3, reset, enable, req, done);
    mb = mstep(mb, 2, reset, enable, req, done);
  end

  // Per-cycle comparison of both instances against their models.
  always @(negedge clk) begin
    if (primed) begin
      chk("a.grant_n",   8'(grant_n_a),   8'(model_gn(ma)));
      chk("a.grant_idx", 8'(grant_idx_a), 8'(ma.shown));
      chk("a.busy",      8'(busy_a),      8'(ma.owner >= 0));
      chk("a.timeout",   8'(timeout_a),   8'(ma.to));
      chk("b.grant_n",   8'(grant_n_b),   8'(model_gn(mb)));
      chk("b.grant_idx", 8'(grant_idx_b), 8'(mb.shown));
      chk("b.busy",      8'(busy_b),      8'(mb.owner >= 0));
      chk("b.timeout",   8'(timeout_b),   8'(mb.to));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  logic [0:3] rr_gn [4];

  initial begin
    rr_gn[0] = 4'b0111; rr_gn[1] = 4'b1011; rr_gn[2] = 4'b1101; rr_gn[3] = 4'b1110;
    reset = 1'b1; enable = 1'b0; req = 4'b0000; done = 1'b0;

    // Reset, single request from requester 1
    step(2);
    chk("lit.reset_gn", 8'(grant_n_a), 8'(4'b1111));
    chk("lit.reset_busy", 8'(busy_a), 8'd0);
    reset = 1'b0; enable = 1'b1; req = req_of(4'b0010);
    step(1);
    chk("lit.single_gn", 8'(grant_n_a), 8'(4'b1011));
    chk("lit.single_idx", 8'(grant_idx_a), 8'd1);
    done = 1'b1;
    step(1);
    chk("lit.done_gn", 8'(grant_n_a), 8'(4'b1111));
    done = 1'b0; req = 4'b0000;
    step(2);

    // Round-robin from a fresh pointer
    reset = 1'b1;
    step(1);
    reset = 1'b0; req = req_of(4'b1111); done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("lit.rr_idx", 8'(grant_idx_a), 8'(i % 4));
      chk("lit.rr_gn", 8'(grant_n_a), 8'(rr_gn[i % 4]));
      if (i < 4) begin
        step(1);
        chk("lit.rr_gap1", 8'(grant_n_a), 8'(4'b1111));
        step(1);
        chk("lit.rr_gap2", 8'(grant_n_a), 8'(4'b1111));
      end
    end
    step(1);
    done = 1'b0; req = 4'b0000;
    step(2);

    // Hold limit on instance a (3 cycles)
    req = req_of(4'b0001);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("lit.hold_gn", 8'(grant_n_a), 8'(4'b0111));
    end
    step(1);
    chk("lit.hold_to", 8'(timeout_a), 8'd1);
    chk("lit.hold_rel_gn", 8'(grant_n_a), 8'(4'b1111));
    step(1);
    chk("lit.hold_to_off", 8'(timeout_a), 8'd0);
    step(1);
    chk("lit.regrant_gn", 8'(grant_n_a), 8'(4'b0111));
    req = 4'b0000;
    step(1);
    chk("lit.drop_to", 8'(timeout_a), 8'd0);
    step(2);

    // Done coinciding with the hold limit on instance b (2 cycles)
    req = req_of(4'b0001);
    step(2);
    chk("lit.sim_b_busy", 8'(busy_b), 8'd1);
    done = 1'b1;
    step(1);
    chk("lit.sim_b_to", 8'(timeout_b), 8'd0);
    chk("lit.sim_b_gn", 8'(grant_n_b), 8'(4'b1111));
    done = 1'b0; req = 4'b0000;
    step(2);

    // Enable gating, then request drop mid-grant
    enable = 1'b0; req = req_of(4'b0100);
    step(3);
    chk("lit.noen_gn", 8'(grant_n_a), 8'(4'b1111));
    enable = 1'b1;
    step(1);
    chk("lit.en_gn", 8'(grant_n_a), 8'(4'b1101));
    chk("lit.en_idx", 8'(grant_idx_a), 8'd2);
    step(1);
    req = 4'b0000;
    step(1);
    chk("lit.drop2_gn", 8'(grant_n_a), 8'(4'b1111));
    chk("lit.drop2_to", 8'(timeout_a), 8'd0);
    step(1);

    // Reset in the middle of a grant
    req = req_of(4'b0100);
    step(1);
    chk("lit.pre_rst_gn", 8'(grant_n_a), 8'(4'b1101));
    reset = 1'b1;
    step(1);
    chk("lit.rst_gn", 8'(grant_n_a), 8'(4'b1111));
    chk("lit.rst_busy", 8'(busy_a), 8'd0);
    chk("lit.rst_idx", 8'(grant_idx_a), 8'd0);
    reset = 1'b0; req = req_of(4'b1111);
    step(1);
    chk("lit.post_rst_idx", 8'(grant_idx_a), 8'd0);
    chk("lit.post_rst_gn", 8'(grant_n_a), 8'(4'b0111));
    done = 1'b1;
    step(1);
    done = 1'b0; req = 4'b0000;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time bound, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
